logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised successor to the fixed 32-bit bitwise gates: one WIDTH-bit
//  bitwise unit with selectable op (AND/OR/XOR/NOR) and an internal accumulator.
//  Registered result with valid/ready handshakes on input and output.
//  Sits between the operand source and the writeback stage of the datapath.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=1)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      unit can accept a beat this cycle
//  op         in   2      00 AND, 01 OR, 10 XOR, 11 NOR
//  acc_sel    in   1      1: operand A replaced by accumulator value
//  acc_clr    in   1      synchronous clear of accumulator
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      result register holds an undelivered result
//  out_ready  in   1      consumer accepts result this cycle
//  y          out  WIDTH  result
//  zero       out  1      y == 0
//  ones       out  1      y == all ones
//  parity     out  1      XOR-reduction of y
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, y=0, zero=0, ones=0, parity=0, acc=0.
//    Any in-flight result is discarded. in_ready reads 1 while out_valid=0.
//  - in_ready = !out_valid || out_ready (combinational; the unit has no skid
//    buffer). accept = in_valid && in_ready. deliver = out_valid && out_ready.
//  - Latency: 1 cycle. On accept, at the next edge: y = opA OP b, where
//    opA = acc_sel ? acc : a. Flags are computed from the new y in the same
//    edge (registered alongside it). out_valid becomes 1.
//  - deliver without accept: out_valid becomes 0; y and flags hold.
//  - deliver and accept in the same cycle: the new result replaces the old one
//    with no bubble, and out_valid stays 1.
//  - No accept and no deliver: all outputs hold (stall). y is stable while
//    out_valid=1 && !out_ready.
//  - Accumulator: on each accept, acc <= result (this happens whether or not
//    acc_sel is set).
//  - acc_clr=1 forces acc <= 0 at the edge. This overrides the accept update.
//    A beat accepted in the same cycle still uses the pre-clear acc as opA.
//    acc_clr acts independently of handshakes and does not touch y/out_valid.
//  - Width rules: all ops are purely bitwise; no carries. NOR = ~(opA | b).
//    ones uses the full WIDTH. For WIDTH=1, parity = y.
//  - in_valid/op/a/b are sampled only on accept and are don't-care otherwise.
// TESTING
//  1 WIDTH=32, op=01, a=17F13EE8, b=B0997F07 -> next cycle out_valid=1,
//    y=B7F97FEF, zero=0, ones=0.
//  2 Same a/b, op=00 then 10 back-to-back with out_ready=1 -> y=10913E00,
//    then y=A76841EF. One result per cycle, no bubble.
//  3 op=11, a=0, b=0 -> y=FFFFFFFF, ones=1, parity=0. Then op=00, b=0 ->
//    y=0, zero=1.
//  4 acc_clr=1, then acc_sel=1 op=01 b=0000000F, then b=000000F0 ->
//    y=0000000F, then y=000000FF. Then acc_clr+accept (b=0) gives y=000000FF,
//    and the next acc OR 0 gives y=0.
//  5 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, y held, no beat
//    lost. Release -> the queued beat is accepted on the release cycle.
//  6 Assert rst mid-stall (out_valid=1) -> out_valid, y and acc go to 0
//    immediately (async), and in_ready=1 after reset.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit bitwise unit (AND/OR/XOR/NOR) with accumulator feedback and a
// single registered result stage under valid/ready flow control.
module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             acc_sel,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] res;
  logic             accept;
  logic             deliver;

  // No skid buffer: a new beat is taken only if the slot is free or draining.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  assign op_a = acc_sel ? acc : a;

  always_comb begin
    res = '0;
    case (op)
      OP_AND:  res = op_a & b;
      OP_OR:   res = op_a | b;
      OP_XOR:  res = op_a ^ b;
      OP_NOR:  res = ~(op_a | b);
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      ones      <= 1'b0;
      parity    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= res;
      zero      <= (res == '0);
      ones      <= &res;
      parity    <= ^res;
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

  // Clear wins over the accept update; the accepted beat still saw the old acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (accept) begin
      acc <= res;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed vectors plus a randomized phase, with
// every delivered result checked against a queue of expected results.
module tb_logic_unit_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic         acc_sel = 1'b0;
  logic         acc_clr = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y;
  logic         zero;
  logic         ones;
  logic         parity;

  typedef struct packed {
    logic [W-1:0] y;
    logic         zero;
    logic         ones;
    logic         parity;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         e;
  logic [W-1:0] m_acc = '0;
  logic [W-1:0] m_opa;
  logic [W-1:0] m_res;
  int           n_checks = 0;
  int           n_errors = 0;

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_sel(acc_sel), .acc_clr(acc_clr), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .zero(zero), .ones(ones), .parity(parity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] z);
    case (o)
      2'b00:   return x & z;
      2'b01:   return x | z;
      2'b10:   return x ^ z;
      default: return ~(x | z);
    endcase
  endfunction

  // Scoreboard: sampled mid-cycle, ahead of the edge that acts on the handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      m_acc = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          chk("sb_y", 64'(y), 64'(e.y));
          chk("sb_zero", 64'(zero), 64'(e.zero));
          chk("sb_ones", 64'(ones), 64'(e.ones));
          chk("sb_parity", 64'(parity), 64'(e.parity));
        end
      end
      m_res = '0;
      if (in_valid && in_ready) begin
        m_opa = acc_sel ? m_acc : a;
        m_res = ref_op(op, m_opa, b);
        sb_q.push_back('{y: m_res, zero: (m_res == '0), ones: (m_res == {W{1'b1}}),
                         parity: ^m_res});
      end
      if (acc_clr) m_acc = '0;
      else if (in_valid && in_ready) m_acc = m_res;
    end
  end

  // Offer one beat and wait (bounded) for it to be accepted; returns #1 after that edge.
  task automatic beat(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic s, input logic c);
    bit ok;
    ok = 1'b0;
    op = o; a = av; b = bv; acc_sel = s; acc_clr = c; in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; acc_sel = 1'b0; acc_clr = 1'b0;
    if (!ok) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_flags", {61'd0, zero, ones, parity}, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // OR vector
    beat(2'b01, 32'h17F13EE8, 32'hB0997F07, 1'b0, 1'b0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_y", 64'(y), 64'hB7F97FEF);
    chk("t1_zero_ones", {62'd0, zero, ones}, 64'd0);

    // back-to-back AND then XOR, no bubble
    op = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("t2_and_y", 64'(y), 64'h10913E00);
    chk("t2_and_valid", 64'(out_valid), 64'd1);
    op = 2'b10;
    @(posedge clk); #1;
    chk("t2_xor_y", 64'(y), 64'hA76841EF);
    chk("t2_xor_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;

    // NOR of zeros, then AND with zero
    beat(2'b11, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t3_nor_y", 64'(y), 64'hFFFFFFFF);
    chk("t3_nor_flags", {61'd0, zero, ones, parity}, {61'd0, 3'b010});
    beat(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t3_and_y", 64'(y), 64'h0);
    chk("t3_and_zero", 64'(zero), 64'd1);

    // accumulator chain; operand a is junk and must be ignored
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    beat(2'b01, 32'hFFFF0000, 32'h0000000F, 1'b1, 1'b0);
    chk("t4_acc1", 64'(y), 64'h0000000F);
    beat(2'b01, 32'hFFFF0000, 32'h000000F0, 1'b1, 1'b0);
    chk("t4_acc2", 64'(y), 64'h000000FF);
    beat(2'b01, 32'hFFFF0000, 32'h0, 1'b1, 1'b1);
    chk("t4_clr_same", 64'(y), 64'h000000FF);
    beat(2'b01, 32'hFFFF0000, 32'h0, 1'b1, 1'b0);
    chk("t4_after_clr", 64'(y), 64'h0);
    chk("t4_after_clr_zero", 64'(zero), 64'd1);

    // stall with a pending beat
    beat(2'b00, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, 1'b0);
    out_ready = 1'b0;
    op = 2'b01; a = 32'h0; b = 32'h12345678; acc_sel = 1'b0; in_valid = 1'b1;
    #1;
    chk("t5_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t5_y_held", 64'(y), 64'hDEADBEEF);
      chk("t5_stall_ready", {62'd0, out_valid, in_ready}, 64'b10);
    end
    out_ready = 1'b1;
    #1;
    chk("t5_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t5_queued_y", 64'(y), 64'h12345678);

    // async reset while stalled
    beat(2'b01, 32'h0F0F0F0F, 32'h0, 1'b0, 1'b0);
    out_ready = 1'b0;
    @(posedge clk); #3;
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_y", 64'(y), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    beat(2'b01, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
    chk("t6_acc_cleared", 64'(y), 64'h0);

    // randomized traffic, checked by the scoreboard
    for (int i = 0; i < 200; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 2'($urandom_range(0, 3));
      acc_sel   = 1'($urandom_range(0, 1));
      acc_clr   = ($urandom_range(0, 7) == 0);
      a         = $urandom;
      b         = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; acc_clr = 1'b0; acc_sel = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
